button_repeat_ctrl: RTL and testbench

Press sequencer for the robot-control button pad. It debounces raw button inputs against the slow tick from the clock-divider counter and arbitrates between simultaneous presses. It emits one-cycle press pulses with hold-to-repeat auto-repeat. It also drives the divider's `select_clk` input, so the tick period itself sets the debounce time, the initial hold delay and an accelerating repeat rate.

---
 rtl/button_repeat_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_button_repeat_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/button_repeat_ctrl.sv
// button_repeat_ctrl
//
// Press sequencer for the robot-control button pad. Raw buttons and the slow
// divider tick are synchronised. A single tracked button is debounced against
// the tick and turned into one-cycle press pulses. When BTN_REPEAT_EN is
// defined, holding the button also produces auto-repeat pulses. In that build
// the select_clk output drives the divider rate, so each stage runs at its own
// tick period and the repeat rate speeds up in steps.
//
// Configuration macro: BTN_REPEAT_EN
//   defined   - HELD/REPEAT stages active, select_clk steps 11 -> 10 -> 01 -> 00
//   undefined - one pulse per press, select_clk stays 00
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   btn_raw    raw buttons, 1 = pressed (asynchronous)
//   tick       divider clock output (asynchronous square wave)
//   select_clk divider rate select, 00 fastest .. 11 slowest
//   btn_pulse  one-hot one-cycle press / repeat event
//   btn_id     index of the tracked button
//   active     high whenever the sequencer is not idle

module button_repeat_ctrl #(
  parameter int N_BTN        = 4,
  parameter int DEB_TICKS    = 3,
  parameter int HOLD_TICKS   = 4,
  parameter int ACCEL_PULSES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_raw,
  input  logic                     tick,
  output logic [1:0]               select_clk,
  output logic [N_BTN-1:0]         btn_pulse,
  output logic [$clog2(N_BTN)-1:0] btn_id,
  output logic                     active
);

  localparam int ID_W    = $clog2(N_BTN);
  localparam int CNT_MAX = (DEB_TICKS > HOLD_TICKS) ? DEB_TICKS : HOLD_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RCNT_W  = $clog2(ACCEL_PULSES + 1);

  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEB_TICKS);
`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0]  HOLD_LIM  = CNT_W'(HOLD_TICKS);
  localparam logic [RCNT_W-1:0] ACCEL_LIM = RCNT_W'(ACCEL_PULSES);
`endif

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    REPEAT,
    RELEASE
  } state_t;

  state_t state, state_next;

  logic [N_BTN-1:0]  btn_meta, btn_sync;
  logic              tick_meta, tick_sync, tick_prev;
  logic              tick_rise, tick_eff;
  logic              blank;

  logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
  logic [RCNT_W-1:0] rcnt, rcnt_next;
`ifdef BTN_REPEAT_EN
  logic [RCNT_W-1:0] rcnt_inc;
`endif
  logic [1:0]        sel_next;
  logic [N_BTN-1:0]  pulse_next;
  logic [ID_W-1:0]   id_next, lowest_id;
  logic              tracked;

  // Two-flop synchronisers for the buttons and the tick, plus one extra tick
  // flop so a rising edge shows up as a single-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta  <= '0;
      btn_sync  <= '0;
      tick_meta <= 1'b0;
      tick_sync <= 1'b0;
      tick_prev <= 1'b0;
    end else begin
      btn_meta  <= btn_raw;
      btn_sync  <= btn_meta;
      tick_meta <= tick;
      tick_sync <= tick_meta;
      tick_prev <= tick_sync;
    end
  end

  assign tick_rise = tick_sync & ~tick_prev;

  // The divider may glitch when its rate changes, so the first tick edge after
  // any select change is swallowed. Only tick_eff advances the sequencer.
  assign tick_eff = tick_rise & ~blank;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank <= 1'b0;
    end else if (sel_next != select_clk) begin
      blank <= 1'b1;
    end else if (tick_rise) begin
      blank <= 1'b0;
    end
  end

  // State and registered outputs. Every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rcnt       <= '0;
      select_clk <= 2'b00;
      btn_pulse  <= '0;
      btn_id     <= '0;
      active     <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      rcnt       <= rcnt_next;
      select_clk <= sel_next;
      btn_pulse  <= pulse_next;
      btn_id     <= id_next;
      active     <= (state_next != IDLE);
    end
  end

  // Next-state logic. A release of the tracked button always takes priority
  // over a tick arriving in the same cycle, so no pulse is emitted then.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rcnt_next  = rcnt;
    sel_next   = select_clk;
    pulse_next = '0;
    id_next    = btn_id;

    lowest_id = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (btn_sync[i]) lowest_id = ID_W'(i);
    end
    tracked = btn_sync[btn_id];
    cnt_inc = cnt + 1'b1;
`ifdef BTN_REPEAT_EN
    rcnt_inc = rcnt + 1'b1;
`endif

    case (state)
      IDLE: begin
        sel_next = 2'b00;
        if (|btn_sync) begin
          id_next    = lowest_id;
          cnt_next   = '0;
          state_next = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (!tracked) begin
          state_next = IDLE;
        end else if (tick_eff) begin
          if (cnt_inc == DEB_LIM) begin
            pulse_next = {{(N_BTN-1){1'b0}}, 1'b1} << btn_id;
            cnt_next   = '0;
`ifdef BTN_REPEAT_EN
            sel_next   = 2'b11;
            state_next = HELD;
`else
            state_next = RELEASE;
`endif
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end

`ifdef BTN_REPEAT_EN
      HELD: begin
        if (!tracked) begin
          cnt_next   = '0;
          sel_next   = 2'b00;
          state_next = RELEASE;
        end else if (tick_eff) begin
          if (cnt_inc == HOLD_LIM) begin
            pulse_next = {{(N_BTN-1){1'b0}}, 1'b1} << btn_id;
            cnt_next   = '0;
            rcnt_next  = '0;
            sel_next   = 2'b10;
            state_next = REPEAT;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end

      // Each block of ACCEL_PULSES repeats moves the divider one step
      // faster, stopping at the fastest rate.
      REPEAT: begin
        if (!tracked) begin
          cnt_next   = '0;
          sel_next   = 2'b00;
          state_next = RELEASE;
        end else if (tick_eff) begin
          pulse_next = {{(N_BTN-1){1'b0}}, 1'b1} << btn_id;
          if (rcnt_inc == ACCEL_LIM) begin
            rcnt_next = '0;
            if (select_clk != 2'b00) sel_next = select_clk - 2'd1;
          end else begin
            rcnt_next = rcnt_inc;
          end
        end
      end
`endif

      // The whole pad must stay quiet for DEB_TICKS ticks before a new
      // press can be accepted.
      RELEASE: begin
        sel_next = 2'b00;
        if (|btn_sync) begin
          cnt_next = '0;
        end else if (tick_eff) begin
          if (cnt_inc == DEB_LIM) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// Testbench for button_repeat_ctrl. It drives the tick directly, so every tick
// rise is known to the bench. The pulse count and select_clk value it expects
// after k rises of a steady press are worked out from a schedule of rises:
// debounce, one blanked rise, hold, then blocks of repeats. Build with
// BTN_REPEAT_EN defined to match an auto-repeat DUT.

module tb_button_repeat_ctrl;

  localparam int N_BTN = 4;
  localparam int DEB   = 3;
  localparam int HOLD  = 4;
  localparam int ACCEL = 8;
  localparam int HALF  = 8;

`ifdef BTN_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_BTN-1:0] btn_raw = '0;
  logic             tick = 1'b0;
  logic [1:0]       select_clk;
  logic [N_BTN-1:0] btn_pulse;
  logic [1:0]       btn_id;
  logic             active;

  int compared   = 0;
  int mismatched = 0;

  int good_pulses = 0;
  int bad_pulses  = 0;
  int exp_id      = 0;
  bit sel_ever_nonzero = 1'b0;
  logic [N_BTN-1:0] prev_pulse = '0;

  always #5 clk = ~clk;

  button_repeat_ctrl #(
    .N_BTN(N_BTN), .DEB_TICKS(DEB), .HOLD_TICKS(HOLD), .ACCEL_PULSES(ACCEL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .tick(tick),
    .select_clk(select_clk),
    .btn_pulse(btn_pulse),
    .btn_id(btn_id),
    .active(active)
  );

  // Pulse monitor: a pulse is good only if it is one-hot at the expected
  // button and the previous cycle was quiet (one-cycle width).
  always @(negedge clk) begin
    if (btn_pulse != '0) begin
      if (btn_pulse == (4'b0001 << exp_id) && prev_pulse == '0) good_pulses++;
      else bad_pulses++;
    end
    prev_pulse = btn_pulse;
    if (select_clk != 2'b00) sel_ever_nonzero = 1'b1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int lowest_index(input logic [N_BTN-1:0] mask);
    int idx = 0;
    for (int i = N_BTN - 1; i >= 0; i--) if (mask[i]) idx = i;
    return idx;
  endfunction

  // Expected pulses and select value after h tick rises of a steady press.
  function automatic void schedule(input int h, output int pulses, output int sel);
    int r, n;
    pulses = 0;
    sel    = 0;
    if (h < DEB) return;
    pulses = 1;
    if (!REPEAT_EN) return;
    sel = 3;
    r = h - DEB;
    if (r < 1 + HOLD) return;
    r      = r - (1 + HOLD);
    pulses = 2;
    sel    = 2;
    while (r > 0) begin
      r--;
      if (sel == 0) begin
        pulses += r;
        r = 0;
      end else begin
        n = (r < ACCEL) ? r : ACCEL;
        pulses += n;
        r -= n;
        if (n == ACCEL) sel--;
      end
    end
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full tick period with exactly one rising edge in the middle.
  task automatic tick_period();
    tick = 1'b0;
    wait_cycles(HALF);
    tick = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic release_and_settle(input int base, input int pexp);
    btn_raw = '0;
    repeat (DEB + 3) tick_period();
    checkOutput("activeIdle", active, 0);
    checkOutput("selectIdle", select_clk, 0);
    checkOutput("noLatePulse", good_pulses - base, pexp);
    checkOutput("badPulses", bad_pulses, 0);
  endtask

  // Press mask for h tick rises, optionally adding extra buttons after rise
  // extra_at; they must be ignored. Then release everything.
  task automatic applyStimulus(input logic [N_BTN-1:0] mask, input int h,
                               input int extra_at, input logic [N_BTN-1:0] extra);
    int base, pexp, sexp, id_exp;
    id_exp  = lowest_index(mask);
    exp_id  = id_exp;
    base    = good_pulses;
    pexp    = 0;
    btn_raw = mask;
    for (int k = 1; k <= h; k++) begin
      tick_period();
      if (k == extra_at) btn_raw = mask | extra;
      schedule(k, pexp, sexp);
      checkOutput($sformatf("pulses@%0d", k), good_pulses - base, pexp);
      checkOutput($sformatf("select@%0d", k), select_clk, sexp);
    end
    checkOutput("activeHeld", active, 1);
    checkOutput("btnId", btn_id, id_exp);
    release_and_settle(base, pexp);
  endtask

  // Reset asserted in the middle of a long hold, button kept pressed; the
  // press must restart from debounce after reset.
  task automatic reset_during_hold(input logic [N_BTN-1:0] mask, input int h1, input int h2);
    int base, pexp, sexp;
    exp_id  = lowest_index(mask);
    base    = good_pulses;
    btn_raw = mask;
    repeat (h1) tick_period();
    schedule(h1, pexp, sexp);
    checkOutput("preResetPulses", good_pulses - base, pexp);
    checkOutput("preResetSelect", select_clk, sexp);
    tick = 1'b0;
    wait_cycles(4);
    rst = 1'b0;
    #1;
    checkOutput("rstPulse", btn_pulse, 0);
    checkOutput("rstSelect", select_clk, 0);
    checkOutput("rstId", btn_id, 0);
    checkOutput("rstActive", active, 0);
    wait_cycles(3);
    rst  = 1'b1;
    base = good_pulses;
    for (int k = 1; k <= h2; k++) begin
      tick_period();
      schedule(k, pexp, sexp);
      checkOutput($sformatf("postRstPulses@%0d", k), good_pulses - base, pexp);
      checkOutput($sformatf("postRstSelect@%0d", k), select_clk, sexp);
    end
    release_and_settle(base, pexp);
  endtask

  initial begin
    int h, at;
    logic [N_BTN-1:0] mask, extra;

    #3 rst = 1'b0;
    wait_cycles(4);
    checkOutput("resetPulse", btn_pulse, 0);
    checkOutput("resetSelect", select_clk, 0);
    checkOutput("resetId", btn_id, 0);
    checkOutput("resetActive", active, 0);
    rst = 1'b1;
    wait_cycles(2);

    applyStimulus(4'b0100, DEB, 0, 4'b0000);
    applyStimulus(4'b0100, 2, 0, 4'b0000);
    applyStimulus(4'b1010, 8, 2, 4'b0001);
    applyStimulus(4'b0001, 50, 0, 4'b0000);
    reset_during_hold(4'b0010, 20, 6);

    for (int s = 0; s < 12; s++) begin
      mask  = N_BTN'($urandom_range(1, 15));
      h     = $urandom_range(1, 30);
      at    = $urandom_range(0, h);
      extra = N_BTN'($urandom_range(0, 15));
      applyStimulus(mask, h, at, extra);
    end

    checkOutput("selectEverNonzero", sel_ever_nonzero, REPEAT_EN ? 1 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
